// File: rtl/line_unloader.sv
// Line unloader: reads lines 0..lines-1 from the processed line memory one at
// a time, offers each on a valid/ready port and pulses done after the last one.
module line_unloader #(
    parameter int size    = 5,
    parameter int memsize = size * size,
    parameter int lines   = 64,
    parameter int addrw   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               memRead,
    output logic [addrw-1:0]   memAddr,
    input  logic [memsize-1:0] memData,
    output logic [memsize-1:0] outData,
    output logic               outValid,
    input  logic               outReady,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQUEST = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam logic [addrw-1:0] LAST_ADDR = addrw'(lines - 1);

    logic [2:0]         r_state;
    logic [addrw-1:0]   r_addr;
    logic [memsize-1:0] r_data;
    logic               w_accept;
    logic               w_lastLine;

    assign w_accept   = (r_state == S_HOLD) && outReady;
    assign w_lastLine = (r_addr == LAST_ADDR);

    // memAddr stays fixed from Request through Hold, so the read issued in
    // Request and the line offered in Hold always refer to the same address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_state <= S_REQUEST;
                    end
                end
                S_REQUEST: r_state <= S_WAIT;
                S_WAIT: begin
                    r_data  <= memData;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_accept) begin
                        if (w_lastLine) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_addr  <= r_addr + addrw'(1);
                            r_state <= S_REQUEST;
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign memRead  = (r_state == S_REQUEST);
    assign outValid = (r_state == S_HOLD);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FINISH);
    assign memAddr  = r_addr;
    assign outData  = r_data;

endmodule
